// File: rtl/mips_register_file.sv
// -----------------------------------------------------------------------------
// mips_register_file
//
// 32 x 32-bit general-purpose register file for the single-cycle MIPS
// datapath. It sits directly upstream of the ALU/shift stage. Port A supplies
// the value to be shifted (rt). Port B supplies the other ALU operand, or rs
// for variable shifts. Write-back lands on the rising edge that ends the
// instruction.
//
// Ports:
//   clk          datapath clock; all writes on the rising edge
//   rst_n        asynchronous active-low reset; clears every register
//   rd_addr_a    read port A index
//   rd_data_a    read port A data (combinational)
//   rd_addr_b    read port B index
//   rd_data_b    read port B data (combinational)
//   wr_en        write enable (RegWrite)
//   wr_addr      write index (rd or rt, from the RegDst mux)
//   wr_data      write-back data
//   zero_wr_err  sticky flag: a write to $0 was attempted since reset
//
// Optional feature (macro MIPS_REGFILE_BYPASS_EN):
//   When defined, an active write to a non-zero register is forwarded
//   combinationally to any read port addressing the same register. This
//   supports split-phase or pipelined reuse of the file. When undefined,
//   the reads are pure storage reads with no path from wr_data to rd_data.
// -----------------------------------------------------------------------------
module mips_register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              zero_wr_err
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DATA_W-1:0] stored_a;
    logic [DATA_W-1:0] stored_b;
    logic              wr_zero;
    logic              wr_live;

    // A write aimed at $0 is dropped and only raises the error flag.
    // With wr_en low, the terms evaluate to 0 even if wr_addr is X.
    assign wr_zero = wr_en && (wr_addr == '0);
    assign wr_live = wr_en && (wr_addr != '0);

    // NOTE: every register is cleared by the asynchronous reset. Software
    // relies on a known-zero file after reset, so this array must stay in
    // flops and cannot be mapped onto an un-resettable RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            // NOTE: non-blocking assignment. Readers in the same time step
            // must see the pre-edge value.
            regs[wr_addr] <= wr_data;
        end
    end

    // The flag is sticky. Only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_wr_err <= 1'b0;
        end else if (wr_zero) begin
            zero_wr_err <= 1'b1;
        end
    end

    // $0 reads as a hard zero regardless of what the array holds.
    assign stored_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
    assign stored_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];

`ifdef MIPS_REGFILE_BYPASS_EN
    // Forward the in-flight write. wr_live already excludes $0, so $0 is
    // never bypassed.
    always_comb begin
        // NOTE: each output gets a default before the conditional override,
        // so that no latch is inferred.
        rd_data_a = stored_a;
        rd_data_b = stored_b;
        if (wr_live && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
        end
        if (wr_live && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
        end
    end
`else
    assign rd_data_a = stored_a;
    assign rd_data_b = stored_b;
`endif

endmodule

// File: tb/tb_mips_register_file.sv
// -----------------------------------------------------------------------------
// tb_mips_register_file
//
// Self-checking bench for mips_register_file. Expected read values come from
// a bench-side shadow model and from constants. They are pushed to a
// scoreboard queue when the read addresses are driven. After the
// combinational read settles, they are popped and compared. Inputs change on
// the falling edge, and outputs are sampled 1 time unit after the inputs
// change or after the rising edge.
// -----------------------------------------------------------------------------
module tb_mips_register_file;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [DATA_W-1:0] rd_data_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_b;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              zero_wr_err;

    mips_register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_addr_a   (rd_addr_a),
        .rd_data_a   (rd_data_a),
        .rd_addr_b   (rd_addr_b),
        .rd_data_b   (rd_data_b),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .zero_wr_err (zero_wr_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Shadow model of the architectural state.
    logic [DATA_W-1:0] model [32];
    logic              model_err;

    typedef struct {
        string             name;
        bit                port_b;
        logic [DATA_W-1:0] exp;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        logic [ADDR_W-1:0] ra;
        logic [ADDR_W-1:0] rb;
        logic [DATA_W-1:0] ea;
        logic [DATA_W-1:0] eb;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = '0;
        model_err = 1'b0;
    endtask

    // One write through a full clock edge; the shadow model follows.
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        if (a != 0) model[a] = d;
        else        model_err = 1'b1;
    endtask

    // Drive both read addresses, queue the expectations, then drain the queue.
    task automatic expect_reads(input string name,
                                input logic [ADDR_W-1:0] ra, input logic [DATA_W-1:0] ea,
                                input logic [ADDR_W-1:0] rb, input logic [DATA_W-1:0] eb);
        exp_t e;
        rd_addr_a = ra;
        rd_addr_b = rb;
        sb.push_back('{name: {name, "_a"}, port_b: 1'b0, exp: ea});
        sb.push_back('{name: {name, "_b"}, port_b: 1'b1, exp: eb});
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.name, e.port_b ? rd_data_b : rd_data_a, e.exp);
        end
    endtask

    task automatic check_err(input string name, input logic exp);
        check(name, {31'b0, zero_wr_err}, {31'b0, exp});
    endtask

    // Compare every register against the shadow model through both ports.
    task automatic sweep(input string name);
        for (int i = 1; i < 32; i++) begin
            logic [ADDR_W-1:0] a;
            logic [ADDR_W-1:0] b;
            a = ADDR_W'(i);
            b = ADDR_W'(32 - i);
            expect_reads($sformatf("%s_r%0d", name, i), a, model[a], b, model[b]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{wa: 5'd9,  wd: 32'h8000_0001, ra: 5'd9,  rb: 5'd9,  ea: 32'h8000_0001, eb: 32'h8000_0001};
        vecs[1] = '{wa: 5'd1,  wd: 32'hA5A5_A5A5, ra: 5'd1,  rb: 5'd9,  ea: 32'hA5A5_A5A5, eb: 32'h8000_0001};
        vecs[2] = '{wa: 5'd31, wd: 32'h7FFF_FFFF, ra: 5'd31, rb: 5'd0,  ea: 32'h7FFF_FFFF, eb: 32'h0000_0000};
        vecs[3] = '{wa: 5'd0,  wd: 32'hFFFF_FFFF, ra: 5'd0,  rb: 5'd31, ea: 32'h0000_0000, eb: 32'h7FFF_FFFF};
        vecs[4] = '{wa: 5'd9,  wd: 32'h0000_0000, ra: 5'd9,  rb: 5'd1,  ea: 32'h0000_0000, eb: 32'hA5A5_A5A5};
        vecs[5] = '{wa: 5'd16, wd: 32'h0001_0000, ra: 5'd16, rb: 5'd15, ea: 32'h0001_0000, eb: 32'h0000_0000};

        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr_a = '0; rd_addr_b = '0;
        model_reset();
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Reset state.
        check_err("reset_err", 1'b0);
        sweep("reset");

        // A single write is visible on both ports, and nothing else changes.
        do_write(5'd9, 32'h8000_0001);
        expect_reads("wr9", 5'd9, 32'h8000_0001, 5'd9, 32'h8000_0001);
        sweep("after_wr9");

        // Table-driven write/read vectors.
        for (int i = 0; i < 6; i++) begin
            do_write(vecs[i].wa, vecs[i].wd);
            expect_reads($sformatf("vec%0d", i), vecs[i].ra, vecs[i].ea,
                         vecs[i].rb, vecs[i].eb);
        end

        // Restart from reset for the $0 protection sequence, so that the
        // error flag starts out clear.
        @(negedge clk); rst_n = 1'b0; model_reset();
        @(negedge clk); rst_n = 1'b1;
        #1;
        check_err("zero_pre_err", 1'b0);
        do_write(5'd0, 32'hFFFF_FFFF);
        expect_reads("zero_rd", 5'd0, 32'h0, 5'd0, 32'h0);
        check_err("zero_err_set", 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_err($sformatf("zero_err_hold%0d", i), 1'b1);
        end

        // While wr_en is low, writes are ignored, including X on the
        // address and data.
        do_write(5'd3, 32'h1234_5678);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            wr_en = 1'b0;
            wr_addr = (i == 4) ? 'x : 5'd3;
            wr_data = (i == 4) ? 'x : 32'h0;
            @(posedge clk);
        end
        #1;
        expect_reads("wr_dis", 5'd3, 32'h1234_5678, 5'd0, 32'h0);
        sweep("wr_dis");

        // Same-cycle read and write on $7.
        do_write(5'd7, 32'h0000_0011);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000_0022;
`ifdef MIPS_REGFILE_BYPASS_EN
        expect_reads("rw7_pre", 5'd7, 32'h0000_0022, 5'd3, 32'h1234_5678);
`else
        expect_reads("rw7_pre", 5'd7, 32'h0000_0011, 5'd3, 32'h1234_5678);
`endif
        @(posedge clk); #1;
        wr_en = 1'b0; model[7] = 32'h0000_0022;
        expect_reads("rw7_post", 5'd7, 32'h0000_0022, 5'd7, 32'h0000_0022);

        // A write to $0 is never forwarded.
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hCAFE_F00D;
        expect_reads("zero_nobyp", 5'd0, 32'h0, 5'd0, 32'h0);
        @(posedge clk); #1;
        wr_en = 1'b0;

        // Feed the downstream srl: the value comes from A, the shift amount
        // from B[4:0].
        do_write(5'd4, 32'hF000_0000);
        do_write(5'd2, 32'h0000_0004);
        rd_addr_a = 5'd4; rd_addr_b = 5'd2;
        #1;
        check("shift_feed", rd_data_a >> rd_data_b[4:0], 32'h0F00_0000);

        // Asynchronous reset in the middle of the cycle, after $5 is loaded.
        do_write(5'd5, 32'hDEAD_BEEF);
        expect_reads("pre_rst5", 5'd5, 32'hDEAD_BEEF, 5'd0, 32'h0);
        check_err("pre_rst_err", 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        expect_reads("async_rst5", 5'd5, 32'h0, 5'd4, 32'h0);
        check_err("async_rst_err", 1'b0);

        // A write edge that arrives while reset is held must have no effect.
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1234_0000;
        @(posedge clk); #1;
        @(negedge clk);
        wr_en = 1'b0;
        rst_n = 1'b1;
        #1;
        expect_reads("rst_wins", 5'd5, 32'h0, 5'd7, 32'h0);
        sweep("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_register_file.md
Name: mips_register_file

Overview:
- 32 x 32-bit general-purpose register file for the single-cycle MIPS datapath.
- Directly upstream of the ALU/shift stage: read port A supplies the value to be shifted (rt for srl/sll), port B supplies the other ALU operand or rs for variable shifts (low 5 bits used as shift amount).
- Write-back from the ALU/shift result mux lands here on the clock edge that ends the instruction.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; depth = 2**ADDR_W.

Ports:
- clk  input  1  datapath clock; all writes on rising edge.
- rst_n  input  1  asynchronous active-low reset; clears every register.
- rd_addr_a  input  ADDR_W  read port A index.
- rd_data_a  output  DATA_W  read port A data.
- rd_addr_b  input  ADDR_W  read port B index.
- rd_data_b  output  DATA_W  read port B data.
- wr_en  input  1  write enable (RegWrite).
- wr_addr  input  ADDR_W  write index (rd or rt, from RegDst mux).
- wr_data  input  DATA_W  write-back data.
- zero_wr_err  output  1  sticky flag: a write to $0 was attempted.

Behaviour:
- Reset: rst_n low clears regs[0..31] to 0 and zero_wr_err to 0 immediately, independent of clk.
  - Read outputs therefore show 0 while reset is low.
  - Reset asserted mid-write (same cycle as a wr_en edge): reset wins; the register stays 0.
- Write:
  - On posedge clk with rst_n high and wr_en=1, regs[wr_addr] <= wr_data.
  - Latency 1 cycle; the new value is visible on the read ports after the edge.
- Register $0:
  - Never written; rd_data for index 0 is always 0.
  - A write with wr_en=1, wr_addr=0 is dropped and sets zero_wr_err=1 at that edge.
  - zero_wr_err stays 1 until rst_n is asserted.
- Read: combinational; rd_data_x = regs[rd_addr_x], with zero latency so the single-cycle path holds.
- Same-address reads: both ports may address the same register; both return identical data.
- Read and write to the same register in the same cycle: without the optional feature, the read returns the old value until the edge.
- Addressing: every ADDR_W index is valid; no out-of-range case.
- wr_en=0: the storage holds and wr_addr/wr_data are ignored, including X values on them.

Optional Feature:
- Macro: MIPS_REGFILE_BYPASS_EN.
- Defined:
  - Write-to-read forwarding. If wr_en=1, wr_addr!=0 and rd_addr_x==wr_addr, then rd_data_x = wr_data combinationally in the same cycle.
  - Used for split-phase or pipelined reuse of the file.
  - $0 is never bypassed.
- Undefined: pure storage read as described above; no combinational path from wr_data to rd_data_x.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle after loading $5=0xDEADBEEF -> rd_data_a (addr 5)=0 immediately; zero_wr_err=0.
- Write/read: wr_en=1, wr_addr=9, wr_data=0x80000001, one edge; then rd_addr_a=9, rd_addr_b=9 -> both read 0x80000001; all other registers unchanged (sweep 1..31).
- $0 protection: wr_en=1, wr_addr=0, wr_data=0xFFFFFFFF -> rd_data for $0 stays 0; zero_wr_err=1 after the edge and holds across 10 further cycles.
- Write-disable: preload $3=0x12345678; wr_en=0, wr_addr=3, wr_data=0 for 5 edges -> $3 still reads 0x12345678.
- Same-cycle read/write on $7 (old 0x11, new 0x22), read port sampled before the edge:
  - Without MIPS_REGFILE_BYPASS_EN: rd_data_a=0x11 before the edge, 0x22 after.
  - With the macro defined: rd_data_a=0x22 before the edge.
- Shift feed: $4=0xF0000000, $2=0x00000004, read A=4, B=2 into the downstream srl -> shifter output 0x0F000000.
